// File: rtl/gan_pkg.sv
// Purpose: shared constants, FSM state type and a neighbourhood helper for the GAN block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gan_pkg;

  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int PIXEL_COUNT = IMG_W * IMG_H;  // 784
  localparam int IDX_W       = 10;             // enough for 0..PIXEL_COUNT
  localparam int COORD_W     = 5;              // enough for 0..27
  localparam int ACC_W       = 24;
  localparam int SCORE_SHIFT = 4;

  localparam logic [15:0] ONE       = 16'h0100;  // 1.0 in Q8.8
  localparam logic [15:0] BLUR_COEF = 16'h001C;  // ~1/9 in Q8.8

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] CENTRE_LO  = 5'd7;
  localparam logic [COORD_W-1:0] CENTRE_HI  = 5'd20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // collecting bits
    LOAD_FULL = 2'd1,  // frame complete, waiting for start
    RUN       = 2'd2,  // one pixel per cycle
    FINISH    = 2'd3   // latch scores, pulse done
  } state_t;

  // Pixel lookup with zero padding outside the image.
  function automatic logic px_at(input logic [PIXEL_COUNT-1:0] f, input int r, input int c);
    if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return 1'b0;
    return f[IDX_W'(r * IMG_W + c)];
  endfunction

endpackage

// File: rtl/gan_disc_accum.sv
// Purpose: signed +/- accumulator whose sum is shifted and saturated into a Q8.8 score.
// Latency: score/is_real update on the edge where finish is high.
// Backpressure: none; accumulates whenever en is high.
// Ports: clk, rst; clear (zero the sum), en (add a sample), neg (subtract instead),
//        sample (unsigned Q8.8 magnitude), finish (latch score), score, is_real.
module gan_disc_accum
  import gan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic               neg,
  input  logic [15:0]        sample,
  input  logic               finish,
  output logic signed [15:0] score,
  output logic               is_real
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = 24'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -24'sd32768;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] shifted;
  logic signed [15:0]      sat_score;

  // Samples are never negative, so zero-extension is the correct signed view.
  assign term    = signed'({{(ACC_W-16){1'b0}}, sample});
  assign shifted = acc_q >>> SCORE_SHIFT;

  always_comb begin
    sat_score = shifted[15:0];
    if (shifted > SAT_MAX)      sat_score = 16'sh7FFF;
    else if (shifted < SAT_MIN) sat_score = -16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      score   <= '0;
      is_real <= 1'b0;
    end else begin
      if (clear)   acc_q <= '0;
      else if (en) acc_q <= neg ? acc_q - term : acc_q + term;
      if (finish) begin
        score   <= sat_score;
        is_real <= (sat_score > 16'sd0);
      end
    end
  end

endmodule

// File: rtl/gan_serial_top.sv
// Purpose: bit-serial 28x28 frame loader, 3x3 box-blur generator and centre-weighted discriminator.
// Latency: done pulses 785 cycles after the accepted start edge (784 pixels + 1 finish cycle).
// Backpressure: pixel_bit_ready = !busy; bits arriving once the frame is full are dropped.
// Ports: clk, rst; pixel_bit/pixel_bit_valid/pixel_bit_ready (serial load); start, busy, done;
//        disc_{fake,real}_score and _is_real; generated_frame_flat/_valid; frame_ready.
module gan_serial_top
  import gan_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pixel_bit,
  input  logic                        pixel_bit_valid,
  output logic                        pixel_bit_ready,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        disc_fake_is_real,
  output logic                        disc_real_is_real,
  output logic signed [15:0]          disc_fake_score,
  output logic signed [15:0]          disc_real_score,
  output logic [16*PIXEL_COUNT-1:0]   generated_frame_flat,
  output logic                        generated_frame_valid,
  output logic                        frame_ready
);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         count_q;
  logic [IDX_W-1:0]         k_q;
  logic [COORD_W-1:0]       row_q, col_q;
  logic [PIXEL_COUNT-1:0]   frame_buf;
  logic                     load_fire, start_fire, run_step, finish;
  logic [3:0]               nbr_cnt;
  logic [15:0]              gen_px;
  logic [15:0]              real_px;
  logic                     in_centre;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (pixel_bit_valid && count_q == LAST_IDX) state_d = LOAD_FULL;
      LOAD_FULL: if (start)                                  state_d = RUN;
      RUN:       if (k_q == LAST_IDX)                        state_d = FINISH;
      FINISH:                                                state_d = IDLE;
      default:                                               state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy        = 1'b0;
    frame_ready = 1'b0;
    load_fire   = 1'b0;
    start_fire  = 1'b0;
    run_step    = 1'b0;
    finish      = 1'b0;
    unique case (state_q)
      IDLE:      load_fire   = pixel_bit_valid;  // ready is high in IDLE
      LOAD_FULL: begin
        frame_ready = 1'b1;
        start_fire  = start;
      end
      RUN:       begin
        busy     = 1'b1;
        run_step = 1'b1;
      end
      FINISH:    begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default:   busy = 1'b0;
    endcase
    pixel_bit_ready = !busy;
  end

  // 3x3 neighbourhood popcount around (row_q, col_q), zero-padded at the borders.
  always_comb begin
    nbr_cnt = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nbr_cnt = nbr_cnt + {3'b000, px_at(frame_buf, int'(row_q) + dr, int'(col_q) + dc)};
      end
    end
  end

  assign gen_px    = {12'b0, nbr_cnt} * BLUR_COEF;
  assign real_px   = frame_buf[k_q] ? ONE : 16'h0000;
  assign in_centre = (row_q >= CENTRE_LO) && (row_q <= CENTRE_HI) &&
                     (col_q >= CENTRE_LO) && (col_q <= CENTRE_HI);

  // Datapath: load buffer, pixel walk, generated frame, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q               <= '0;
      k_q                   <= '0;
      row_q                 <= '0;
      col_q                 <= '0;
      frame_buf             <= '0;
      generated_frame_flat  <= '0;
      generated_frame_valid <= 1'b0;
      done                  <= 1'b0;
    end else begin
      done <= finish;
      if (load_fire) begin
        frame_buf[count_q] <= pixel_bit;
        count_q            <= count_q + IDX_W'(1);
      end
      if (start_fire) begin
        k_q                   <= '0;
        row_q                 <= '0;
        col_q                 <= '0;
        generated_frame_valid <= 1'b0;
      end
      if (run_step) begin
        generated_frame_flat[{k_q, 4'b0000} +: 16] <= gen_px;
        k_q <= k_q + IDX_W'(1);
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + COORD_W'(1);
        end else begin
          col_q <= col_q + COORD_W'(1);
        end
      end
      if (finish) begin
        count_q               <= '0;
        generated_frame_valid <= 1'b1;
      end
    end
  end

  gan_disc_accum u_fake (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_fire),
    .en      (run_step),
    .neg     (!in_centre),
    .sample  (gen_px),
    .finish  (finish),
    .score   (disc_fake_score),
    .is_real (disc_fake_is_real)
  );

  gan_disc_accum u_real (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_fire),
    .en      (run_step),
    .neg     (!in_centre),
    .sample  (real_px),
    .finish  (finish),
    .score   (disc_real_score),
    .is_real (disc_real_is_real)
  );

endmodule

// File: tb/tb_gan_serial_top.sv
// Purpose: directed, table-driven check of gan_serial_top load, blur, scoring and control corners.
// Latency: expects done 785 cycles after an accepted start.
// Backpressure: drives bits only while idle; exercises gaps and surplus bits.
module tb_gan_serial_top;

  localparam int W = 28;
  localparam int N = 784;

  logic               clk = 1'b0;
  logic               rst;
  logic               pixel_bit;
  logic               pixel_bit_valid;
  logic               pixel_bit_ready;
  logic               start;
  logic               busy;
  logic               done;
  logic               disc_fake_is_real;
  logic               disc_real_is_real;
  logic signed [15:0] disc_fake_score;
  logic signed [15:0] disc_real_score;
  logic [16*N-1:0]    generated_frame_flat;
  logic               generated_frame_valid;
  logic               frame_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gan_serial_top dut (
    .clk                   (clk),
    .rst                   (rst),
    .pixel_bit             (pixel_bit),
    .pixel_bit_valid       (pixel_bit_valid),
    .pixel_bit_ready       (pixel_bit_ready),
    .start                 (start),
    .busy                  (busy),
    .done                  (done),
    .disc_fake_is_real     (disc_fake_is_real),
    .disc_real_is_real     (disc_real_is_real),
    .disc_fake_score       (disc_fake_score),
    .disc_real_score       (disc_real_score),
    .generated_frame_flat  (generated_frame_flat),
    .generated_frame_valid (generated_frame_valid),
    .frame_ready           (frame_ready)
  );

  typedef struct {
    int pat;       // 0 zeros, 1 ones, 2 centre 14x14 square
    bit gaps;      // toggle valid low between bits
    int extra;     // surplus bits after frame_ready
    int idx0; int exp0;
    int idx1; int exp1;
    int idx2; int exp2;
    int real_score;
    int real_is;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit pat_bit(input int p, input int r, input int c);
    case (p)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (r >= 7 && r <= 20 && c >= 7 && c <= 20);
    endcase
  endfunction

  // Reference blur: neighbour count times 28, zero outside the image.
  function automatic int model_g(input int p, input int r, input int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < W && c + dc >= 0 && c + dc < W)
          if (pat_bit(p, r + dr, c + dc)) n++;
    return n * 28;
  endfunction

  function automatic int model_fake_score(input int p);
    int acc = 0;
    int s;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        if (r >= 7 && r <= 20 && c >= 7 && c <= 20) acc += model_g(p, r, c);
        else                                        acc -= model_g(p, r, c);
      end
    s = acc >>> 4;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic int pix(input int i);
    return int'(generated_frame_flat[i*16 +: 16]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    pixel_bit = 1'b0;
    pixel_bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_frame(input int p, input bit gaps, input int extra);
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 3 == 1)) begin
        pixel_bit_valid = 1'b0;
        pixel_bit = ~pat_bit(p, i / W, i % W);
        @(negedge clk);
      end
      if (i == N - 1) check("frame_ready_before_last", int'(frame_ready), 0);
      pixel_bit = pat_bit(p, i / W, i % W);
      pixel_bit_valid = 1'b1;
      @(negedge clk);
    end
    pixel_bit_valid = 1'b0;
    check("frame_ready_after_load", int'(frame_ready), 1);
    for (int j = 0; j < extra; j++) begin
      pixel_bit = 1'b1;
      pixel_bit_valid = (j % 2 == 0);
      @(negedge clk);
    end
    pixel_bit_valid = 1'b0;
  endtask

  // Pulse start, poke a stray start mid-run, and return the cycles from start edge to done.
  task automatic run_frame(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("gen_valid_cleared", int'(generated_frame_valid), 0);
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 100) start = 1'b1;
      if (lat == 101) begin
        start = 1'b0;
        check("busy_held_on_stray_start", int'(busy), 1);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;

    vecs[0] = '{0, 1'b0, 0,   0, 'h00,   405, 'h00, 783, 'h00,      0, 0};
    vecs[1] = '{1, 1'b0, 0,   0, 'h70,   145, 'hFC,   5, 'hA8,  -6272, 0};
    vecs[2] = '{2, 1'b0, 0, 203, 'h70,   290, 'hFC,   0, 'h00,   3136, 1};
    vecs[3] = '{2, 1'b1, 40, 203, 'h70,  290, 'hFC,   0, 'h00,   3136, 1};

    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_frame_ready", int'(frame_ready), 0);
    check("rst_gen_valid", int'(generated_frame_valid), 0);
    check("rst_ready", int'(pixel_bit_ready), 1);
    check("rst_fake_score", int'(disc_fake_score), 0);
    check("rst_real_score", int'(disc_real_score), 0);

    // Start with no frame loaded must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("early_start_busy", int'(busy), 0);
    check("early_start_done", int'(done), 0);

    for (int v = 0; v < 4; v++) begin
      load_frame(vecs[v].pat, vecs[v].gaps, vecs[v].extra);
      run_frame(lat);
      check($sformatf("v%0d_done_latency", v), lat, 785);
      check($sformatf("v%0d_busy_at_done", v), int'(busy), 0);
      check($sformatf("v%0d_gen_valid", v), int'(generated_frame_valid), 1);
      check($sformatf("v%0d_pix_a", v), pix(vecs[v].idx0), vecs[v].exp0);
      check($sformatf("v%0d_pix_b", v), pix(vecs[v].idx1), vecs[v].exp1);
      check($sformatf("v%0d_pix_c", v), pix(vecs[v].idx2), vecs[v].exp2);
      check($sformatf("v%0d_real_score", v), int'(disc_real_score), vecs[v].real_score);
      check($sformatf("v%0d_real_is_real", v), int'(disc_real_is_real), vecs[v].real_is);
      check($sformatf("v%0d_fake_score", v), int'(disc_fake_score), model_fake_score(vecs[v].pat));
      check($sformatf("v%0d_fake_is_real", v), int'(disc_fake_is_real),
            (model_fake_score(vecs[v].pat) > 0) ? 1 : 0);
      bad = 0;
      for (int i = 0; i < N; i++)
        if (pix(i) != model_g(vecs[v].pat, i / W, i % W)) bad++;
      check($sformatf("v%0d_gen_frame_mismatches", v), bad, 0);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", v), int'(done), 0);
      check($sformatf("v%0d_frame_ready_cleared", v), int'(frame_ready), 0);
      check($sformatf("v%0d_ready_after_done", v), int'(pixel_bit_ready), 1);
    end

    // Reset in the middle of a run.
    load_frame(1, 1'b0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("midrun_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    pixel_bit = 1'b1;
    pixel_bit_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pixel_bit_valid = 1'b0;
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_frame_ready", int'(frame_ready), 0);
    check("midrun_rst_gen_valid", int'(generated_frame_valid), 0);
    check("midrun_rst_fake_score", int'(disc_fake_score), 0);
    check("midrun_rst_real_score", int'(disc_real_score), 0);
    check("midrun_rst_ready", int'(pixel_bit_ready), 1);
    repeat (800) @(negedge clk);
    check("midrun_rst_no_done", int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gan_serial_top.md
Name: gan_serial_top

Overview:
Top-level GAN inference block with a serial 1-bit pixel loader. It collects a 28x28 binary frame over a valid/ready bit stream. On start it runs a fixed-weight generator (3x3 box blur producing a Q8.8 frame) and a fixed-weight discriminator, which scores both the generated frame and the real input frame. Sits between a bit-serial image source and software or host inspection of the flattened generated frame and scores.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height; PIXEL_COUNT = IMG_W*IMG_H = 784
BLUR_COEF, 16'h001C, Q8.8 generator tap weight (approx. 1/9)
SCORE_SHIFT, 4, arithmetic right shift applied to discriminator sums

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-high reset
pixel_bit  in  1  serial pixel value (1 = on)
pixel_bit_valid  in  1  pixel_bit is valid this cycle
pixel_bit_ready  out  1  block accepts a bit this cycle
start  in  1  request processing of the loaded frame
busy  out  1  processing in progress
done  out  1  one-cycle pulse at completion
disc_fake_is_real  out  1  disc_fake_score > 0
disc_real_is_real  out  1  disc_real_score > 0
disc_fake_score  out  16 signed Q8.8  discriminator score of generated frame
disc_real_score  out  16 signed Q8.8  discriminator score of input frame
generated_frame_flat  out  16*784  pixel i at bits [(i+1)*16-1 -: 16], i = row*28+col
generated_frame_valid  out  1  generated frame and scores hold valid results
frame_ready  out  1  full frame of 784 bits is loaded

Behaviour:
- Reset: all registered outputs are 0, the bit counter is 0, and the frame buffer is cleared. pixel_bit_ready = !busy (combinational), so it is 1 once out of reset. Bits presented while rst=1 are ignored.
- Load: on each edge with valid && ready && !frame_ready, store the bit at buffer[count] and increment count. When the 784th bit is stored, frame_ready=1 from the next cycle. While frame_ready=1, bits are still accepted but discarded.
- Start is honoured only when frame_ready=1 and busy=0; otherwise it is ignored. On the accepting edge: busy=1, frame_ready=0, generated_frame_valid=0, pixel index k=0.
- Processing, one pixel per cycle, k = 0..783:
  - Generated pixel g[k] = n*BLUR_COEF, where n is the count of set bits in the 3x3 neighbourhood including the centre. Out-of-image neighbours count as 0, so the maximum value is 9*28 = 0x00FC.
  - Real pixel r[k] = bit ? 16'h0100 : 0.
  - Weight w = +1 if row and col are both in 7..20 (the centre 14x14 region), else -1.
  - Two 24-bit signed accumulators add w*g[k] and w*r[k].
- Completion: on the edge after pixel 783 (785 cycles after the start edge):
  - Each score = acc >>> SCORE_SHIFT, saturated to [-32768, 32767].
  - is_real = score > 0.
  - done=1 for exactly one cycle; busy=0; generated_frame_valid=1; bit counter = 0, ready for a new frame.
- All outputs hold their values until the next accepted start or reset.
- Reset mid-load or mid-processing aborts immediately to the reset state.
- The input buffer is read-only during processing; a new load starts only after done.

Decomposition:
- Package gan_pkg: IMG_W, IMG_H, PIXEL_COUNT, Q8.8 constants (ONE = 16'h0100), BLUR_COEF, accumulator width 24, and the state enum IDLE/LOAD_FULL/RUN/FINISH.
- One sub-module, gan_disc_accum: a signed weighted accumulator with shift and saturation, instantiated twice (fake and real).

Test Plan:
- Reset, then 784 zero bits, then start -> frame_ready=1 after the last bit; all generated pixels 0x0000; both scores 0; both is_real=0; done pulses exactly 785 cycles after start.
- All-ones frame -> corner pixel 0 = 0x0070; interior pixel (row 5, col 5) = 0x00FC; edge pixel (row 0, col 5) = 0x00A8; disc_real_score = -6272; disc_real_is_real=0.
- Ones only in the centre 14x14 square (rows/cols 7..20) -> disc_real_score = 3136; disc_real_is_real=1; generated pixel at (7,7) = 0x0070; generated pixel at (10,10) = 0x00FC.
- Start asserted before frame_ready, and again while busy=1 -> ignored: no busy change and no extra done.
- rst asserted mid-run (busy=1) -> next cycle busy=0, frame_ready=0, generated_frame_valid=0, scores 0, pixel_bit_ready=1.
- Extra bits sent after frame_ready=1, with valid toggling through gaps -> stored frame unchanged; results identical to the clean run.
